// File: rtl/oam_dma_if.sv
// CPU-port bundle shared by the sprite DMA engine (master) and the memory-map side (slave).
interface oam_dma_if;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        bus_sel;
    logic [15:0] dma_addr_out;
    logic [7:0]  dma_data_out;
    logic        dma_read_en;
    logic        dma_write_en;
    logic        dma_busy;
    logic        dma_done;

    modport master (
        input  cpu_addr_in, cpu_data_in, cpu_write_en, mem_data_in,
        output cpu_halt, bus_sel, dma_addr_out, dma_data_out,
        output dma_read_en, dma_write_en, dma_busy, dma_done
    );

    modport slave (
        output cpu_addr_in, cpu_data_in, cpu_write_en, mem_data_in,
        input  cpu_halt, bus_sel, dma_addr_out, dma_data_out,
        input  dma_read_en, dma_write_en, dma_busy, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA: a $4014 write halts the CPU and copies page $XX00-$XXFF to $2004.
// Optional OAM_DMA_ALIGN_EN inserts one ALIGN cycle when the free-running parity is odd in HALT.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic       clk,
    input  logic       rst,
    oam_dma_if.master  bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t      state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        halt_q;
    logic        done_q;
    logic        rd_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic        trig;

    assign trig = bus.cpu_write_en && (bus.cpu_addr_in == DMA_TRIG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic parity;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity <= 1'b0;
        else     parity <= ~parity;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            halt_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        page   <= bus.cpu_data_in;
                        idx    <= 8'h00;
                        halt_q <= 1'b1;
                        state  <= HALT;
                    end
                end
                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    if (parity) begin
                        state <= ALIGN;
                    end else begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        addr_q <= {page, idx};
                    end
`else
                    state  <= READ;
                    rd_q   <= 1'b1;
                    addr_q <= {page, idx};
`endif
                end
                ALIGN: begin
                    state  <= READ;
                    rd_q   <= 1'b1;
                    addr_q <= {page, idx};
                end
                READ: begin
                    state  <= WRITE;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b1;
                    addr_q <= OAM_DATA_ADDR;
                end
                WRITE: begin
                    // idx wraps within the byte so page $FF never carries into $0000
                    idx  <= idx + 8'd1;
                    wr_q <= 1'b0;
                    if (idx == 8'hFF) begin
                        state  <= IDLE;
                        halt_q <= 1'b0;
                        done_q <= 1'b1;
                        addr_q <= 16'h0000;
                    end else begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        addr_q <= {page, idx + 8'd1};
                    end
                end
                default: begin
                    state  <= IDLE;
                    halt_q <= 1'b0;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    addr_q <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.cpu_halt     = halt_q;
    assign bus.bus_sel      = halt_q;
    assign bus.dma_busy     = halt_q;
    assign bus.dma_done     = done_q;
    assign bus.dma_read_en  = rd_q;
    assign bus.dma_write_en = wr_q;
    assign bus.dma_addr_out = addr_q;
    // read register upstream holds while read enable is low, so pass it straight through
    assign bus.dma_data_out = wr_q ? bus.mem_data_in : 8'h00;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a one-cycle-latency CPU memory model.
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oam_dma_if bus ();
    oam_dma_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // CPU memory contents: page $02 holds i^$5A at $0200+i
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    logic [7:0] mem_q = 8'h00;
    always @(posedge clk) if (bus.dma_read_en) mem_q <= mem_val(bus.dma_addr_out);
    assign bus.mem_data_in = mem_q;

    int pcnt = 0;
    always @(posedge clk or posedge rst) if (rst) pcnt <= 0; else pcnt <= pcnt + 1;

    logic [15:0] rd_addr [0:4095];
    logic [15:0] wr_addr [0:4095];
    logic [7:0]  wr_data [0:4095];
    int rd_n = 0, wr_n = 0, halt_cnt = 0, done_cnt = 0, oddity = 0;

    always @(negedge clk) begin
        if (bus.dma_read_en && rd_n < 4096) begin rd_addr[rd_n] = bus.dma_addr_out; rd_n++; end
        if (bus.dma_write_en && wr_n < 4096) begin
            wr_addr[wr_n] = bus.dma_addr_out; wr_data[wr_n] = bus.dma_data_out; wr_n++;
        end
        if (bus.cpu_halt) halt_cnt++;
        if (bus.dma_done) done_cnt++;
        if (bus.dma_done && bus.cpu_halt) oddity++;
        if (bus.dma_read_en && bus.dma_write_en) oddity++;
        if (!bus.dma_read_en && !bus.dma_write_en && (bus.dma_addr_out != 16'h0 || bus.dma_data_out != 8'h0)) oddity++;
        if (bus.cpu_halt != bus.bus_sel || bus.cpu_halt != bus.dma_busy) oddity++;
    end

    int exp_halt;
    int rb, wb, hb, db, ob;

    task automatic tick;
        @(negedge clk); #1;
    endtask

    task automatic snap;
        rb = rd_n; wb = wr_n; hb = halt_cnt; db = done_cnt; ob = oddity;
    endtask

    task automatic trig(input logic [7:0] pg);
        tick;
        bus.cpu_addr_in = 16'h4014; bus.cpu_data_in = pg; bus.cpu_write_en = 1'b1;
        tick;
        bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00; bus.cpu_write_en = 1'b0;
        exp_halt = 513;
`ifdef OAM_DMA_ALIGN_EN
        exp_halt = 513 + (pcnt % 2);
`endif
    endtask

    task automatic wait_done;
        int n = 0;
        while (done_cnt == db && n < 700) begin tick; n++; end
        total++;
        if (done_cnt == db) begin bad++; $display("FAIL done_timeout got=%0d want=1", done_cnt - db); end
        tick;
    endtask

    task automatic check_xfer(input logic [7:0] pg, input string nm);
        logic [15:0] a;
        total++; if (halt_cnt - hb != exp_halt) begin bad++; $display("FAIL %s halt_len got=%0d want=%0d", nm, halt_cnt - hb, exp_halt); end
        total++; if (done_cnt - db != 1) begin bad++; $display("FAIL %s done_pulses got=%0d want=1", nm, done_cnt - db); end
        total++; if (rd_n - rb != 256) begin bad++; $display("FAIL %s reads got=%0d want=256", nm, rd_n - rb); end
        total++; if (wr_n - wb != 256) begin bad++; $display("FAIL %s writes got=%0d want=256", nm, wr_n - wb); end
        total++; if (oddity != ob) begin bad++; $display("FAIL %s bus_rules got=%0d want=0", nm, oddity - ob); end
        for (int i = 0; i < 256; i++) begin
            a = {pg, 8'(i)};
            total++;
            if (rd_addr[rb+i] !== a || wr_addr[wb+i] !== 16'h2004 || wr_data[wb+i] !== mem_val(a)) begin
                bad++;
                $display("FAIL %s byte%0d rd=%h/%h wr=%h/%h data=%h/%h", nm, i,
                         rd_addr[rb+i], a, wr_addr[wb+i], 16'h2004, wr_data[wb+i], mem_val(a));
            end
        end
    endtask

    task automatic test_reset;
        bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00; bus.cpu_write_en = 1'b0;
        rst = 1'b1;
        tick; tick;
        total++;
        if ({bus.cpu_halt, bus.bus_sel, bus.dma_busy, bus.dma_done, bus.dma_read_en, bus.dma_write_en} !== 6'b0
            || bus.dma_addr_out !== 16'h0 || bus.dma_data_out !== 8'h0) begin
            bad++; $display("FAIL reset_outputs got=%b/%h/%h want=0", {bus.cpu_halt, bus.bus_sel, bus.dma_busy,
                bus.dma_done, bus.dma_read_en, bus.dma_write_en}, bus.dma_addr_out, bus.dma_data_out);
        end
        rst = 1'b0;
        bus.cpu_addr_in = 16'h4014; bus.cpu_data_in = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (bus.dma_busy !== 1'b0) begin bad++; $display("FAIL read_4014_busy got=%b want=0", bus.dma_busy); end
        end
        bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00;
    endtask

    task automatic test_page02;
        snap;
        trig(8'h02);
        total++; if (bus.cpu_halt !== 1'b1) begin bad++; $display("FAIL halt_after_trig got=%b want=1", bus.cpu_halt); end
        wait_done;
        check_xfer(8'h02, "page02");
    endtask

    task automatic test_page_ff;
        snap;
        trig(8'hFF);
        wait_done;
        check_xfer(8'hFF, "pageFF");
        total++; if (rd_addr[rb+255] !== 16'hFFFF) begin bad++; $display("FAIL pageFF_last got=%h want=ffff", rd_addr[rb+255]); end
    endtask

    task automatic test_retrigger;
        int n = 0;
        snap;
        trig(8'h02);
        while (rd_n - rb < 10 && n < 100) begin tick; n++; end
        bus.cpu_addr_in = 16'h4014; bus.cpu_data_in = 8'h03; bus.cpu_write_en = 1'b1;
        tick;
        bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00; bus.cpu_write_en = 1'b0;
        wait_done;
        check_xfer(8'h02, "retrig");
    endtask

    task automatic test_back_to_back;
        // second trigger lands in the dma_done cycle
        snap;
        trig(8'h05);
        while (done_cnt == db) tick;
        bus.cpu_addr_in = 16'h4014; bus.cpu_data_in = 8'h06; bus.cpu_write_en = 1'b1;
        tick;
        bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00; bus.cpu_write_en = 1'b0;
        total++; if (bus.dma_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", bus.dma_busy); end
        snap; hb = halt_cnt - 1; rb = rd_n;
        exp_halt = 513;
`ifdef OAM_DMA_ALIGN_EN
        exp_halt = 513 + (pcnt % 2);
`endif
        wait_done;
        check_xfer(8'h06, "b2b");
    endtask

    task automatic test_mid_reset;
        int n = 0;
        int w0;
        snap;
        trig(8'h02);
        while (wr_n - wb < 101 && n < 400) begin tick; n++; end
        rst = 1'b1; #1;
        total++;
        if ({bus.cpu_halt, bus.bus_sel, bus.dma_busy, bus.dma_done, bus.dma_read_en, bus.dma_write_en} !== 6'b0
            || bus.dma_addr_out !== 16'h0) begin
            bad++; $display("FAIL midreset_outputs got=%b/%h want=0", {bus.cpu_halt, bus.bus_sel, bus.dma_busy,
                bus.dma_done, bus.dma_read_en, bus.dma_write_en}, bus.dma_addr_out);
        end
        w0 = wr_n;
        tick; tick;
        rst = 1'b0;
        tick; tick;
        total++; if (wr_n != w0) begin bad++; $display("FAIL midreset_writes got=%0d want=%0d", wr_n, w0); end
        snap;
        trig(8'h04);
        wait_done;
        check_xfer(8'h04, "restart04");
    endtask

`ifdef OAM_DMA_ALIGN_EN
    task automatic test_align;
        for (int k = 0; k < 2; k++) begin
            tick;
            snap;
            trig(8'h07);
            wait_done;
            check_xfer(8'h07, "align");
        end
    endtask
`endif

    initial begin
        test_reset;
        test_page02;
        test_page_ff;
        test_retrigger;
        test_back_to_back;
        test_mid_reset;
`ifdef OAM_DMA_ALIGN_EN
        test_align;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
